cdb_wb_scheduler: RTL and testbench



---
 rtl/cdb_wb_scheduler.sv | 133 +++++++++++++
 tb/tb_cdb_wb_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_wb_scheduler.sv
// Writeback-slot scheduler for the two CDB lanes: grants future writeback slots at
// issue time, tracks them in a shifting reservation table and drives lane ownership.
module cdb_wb_scheduler #(
  parameter int HORIZON = 8,
  parameter int LAT_W   = $clog2(HORIZON + 1)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [3:0]                         req_valid,
  input  logic [4*LAT_W-1:0]                 req_lat,
  input  logic [3:0]                         req_thread,
  input  logic                               mispredict_0,
  input  logic                               mispredict_1,
  output logic [3:0]                         grant,
  output logic [3:0]                         grant_lane,
  output logic [1:0]                         wb_valid,
  output logic [3:0]                         wb_src,
  output logic [1:0]                         wb_thread,
  output logic [$clog2(2*HORIZON+1)-1:0]     slots_used,
  output logic                               lat_err
);

  localparam int CNT_W = $clog2(2*HORIZON + 1);

  // slot[d] holds the writebacks due d cycles from now, one bit/field per lane
  logic [1:0] slot_valid  [HORIZON];
  logic [1:0] slot_thread [HORIZON];
  logic [1:0] slot_src    [HORIZON][2];

  logic [1:0] nxt_valid   [HORIZON];
  logic [1:0] nxt_thread  [HORIZON];
  logic [1:0] nxt_src     [HORIZON][2];
  logic [CNT_W-1:0] nxt_count;

  logic [LAT_W-1:0] lat [4];
  logic [3:0]       legal;
  logic [1:0]       squash;
  logic [1:0]       occ [HORIZON+1];
  logic [1:0]       idx;

  assign squash = {mispredict_1, mispredict_0};

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      lat[i]   = req_lat[i*LAT_W +: LAT_W];
      legal[i] = (lat[i] != '0) && (lat[i] <= LAT_W'(HORIZON));
    end
  end

  assign lat_err = |(req_valid & ~legal);

  // Grants are resolved in fixed priority (mult, branch, ALU0, ALU1); occ carries
  // the table occupancy merged with grants already made this cycle.
  always_comb begin
    grant      = '0;
    grant_lane = '0;
    idx        = '0;
    for (int unsigned d = 0; d < HORIZON; d++)
      occ[d] = slot_valid[d];
    occ[HORIZON] = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      idx = 2'(p + 2);
      if (!reset && req_valid[idx] && legal[idx] && !squash[req_thread[idx]]
          && occ[lat[idx]] != 2'b11) begin
        grant[idx]                    = 1'b1;
        grant_lane[idx]               = occ[lat[idx]][0];
        occ[lat[idx]][grant_lane[idx]] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned d = 0; d < HORIZON - 1; d++) begin
      nxt_valid[d]  = slot_valid[d+1];
      nxt_thread[d] = slot_thread[d+1];
      nxt_src[d][0] = slot_src[d+1][0];
      nxt_src[d][1] = slot_src[d+1][1];
    end
    nxt_valid[HORIZON-1]  = '0;
    nxt_thread[HORIZON-1] = '0;
    nxt_src[HORIZON-1][0] = '0;
    nxt_src[HORIZON-1][1] = '0;

    // A latency-L grant targets slot[L] before the shift, i.e. slot[L-1] after it
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned d = 0; d < HORIZON; d++) begin
        if (grant[i] && lat[i] == LAT_W'(d + 1)) begin
          nxt_valid[d][grant_lane[i]]  = 1'b1;
          nxt_thread[d][grant_lane[i]] = req_thread[i];
          nxt_src[d][grant_lane[i]]    = 2'(i);
        end
      end
    end

    nxt_count = '0;
    for (int unsigned d = 0; d < HORIZON; d++) begin
      for (int unsigned k = 0; k < 2; k++) begin
        if (squash[nxt_thread[d][k]])
          nxt_valid[d][k] = 1'b0;
        nxt_count = nxt_count + CNT_W'(nxt_valid[d][k]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned d = 0; d < HORIZON; d++) begin
        slot_valid[d]  <= '0;
        slot_thread[d] <= '0;
        slot_src[d][0] <= '0;
        slot_src[d][1] <= '0;
      end
      slots_used <= '0;
    end else begin
      for (int unsigned d = 0; d < HORIZON; d++) begin
        slot_valid[d]  <= nxt_valid[d];
        slot_thread[d] <= nxt_thread[d];
        slot_src[d][0] <= nxt_src[d][0];
        slot_src[d][1] <= nxt_src[d][1];
      end
      slots_used <= nxt_count;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < 2; k++)
      wb_valid[k] = slot_valid[0][k] & ~squash[slot_thread[0][k]];
  end

  assign wb_src    = {slot_src[0][1], slot_src[0][0]};
  assign wb_thread = slot_thread[0];

endmodule

// File: tb/tb_cdb_wb_scheduler.sv
// Bench for cdb_wb_scheduler: reservation-list reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cdb_wb_scheduler;
  localparam int H  = 8;
  localparam int LW = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_lat = '0;
  logic [3:0]  req_thread = '0;
  logic        mispredict_0 = 1'b0;
  logic        mispredict_1 = 1'b0;
  logic [3:0]  grant;
  logic [3:0]  grant_lane;
  logic [1:0]  wb_valid;
  logic [3:0]  wb_src;
  logic [1:0]  wb_thread;
  logic [4:0]  slots_used;
  logic        lat_err;

  always #5 clock = ~clock;

  cdb_wb_scheduler #(.HORIZON(H)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_lat(req_lat),
    .req_thread(req_thread), .mispredict_0(mispredict_0), .mispredict_1(mispredict_1),
    .grant(grant), .grant_lane(grant_lane), .wb_valid(wb_valid), .wb_src(wb_src),
    .wb_thread(wb_thread), .slots_used(slots_used), .lat_err(lat_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a list of reservations keyed by absolute writeback cycle
  typedef struct {int due; int lane; int src; int th;} res_t;
  res_t rq[$];
  int now = 0;
  int exp_slots = 0;

  function automatic bit occupied(input int t, input int k);
    foreach (rq[j]) if (rq[j].due == t && rq[j].lane == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit squashed(input int th);
    return (th == 0 && mispredict_0) || (th == 1 && mispredict_1);
  endfunction

  task automatic model_cycle();
    logic [3:0] eg, el;
    bit err;
    res_t keep[$];
    eg = '0; el = '0; err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int L;
      L = int'(req_lat[i*LW +: LW]);
      if (req_valid[i] && (L == 0 || L > H)) err = 1'b1;
    end
    if (!reset) begin
      for (int p = 0; p < 4; p++) begin
        int i, L, th;
        bit o0, o1;
        i  = (p + 2) % 4;
        L  = int'(req_lat[i*LW +: LW]);
        th = int'(req_thread[i]);
        if (req_valid[i] && L >= 1 && L <= H && !squashed(th)) begin
          o0 = occupied(now + L, 0);
          o1 = occupied(now + L, 1);
          if (!(o0 && o1)) begin
            eg[i] = 1'b1;
            el[i] = o0;
            rq.push_back('{now + L, int'(o0), i, th});
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      bit found;
      int es, et;
      found = 1'b0; es = 0; et = 0;
      foreach (rq[j]) if (rq[j].due == now && rq[j].lane == k) begin
        found = 1'b1; es = rq[j].src; et = rq[j].th;
      end
      chk("wb_valid_lane", int'(wb_valid[k]), int'(found && !squashed(et)));
      if (found) begin
        chk("wb_src_lane", int'(wb_src[2*k +: 2]), es);
        chk("wb_thread_lane", int'(wb_thread[k]), et);
      end
    end
    chk("grant", int'(grant), int'(eg));
    chk("grant_lane", int'(grant_lane), int'(el));
    chk("lat_err", int'(lat_err), int'(err));
    chk("slots_used", int'(slots_used), exp_slots);
    if (reset) rq.delete();
    else begin
      foreach (rq[j]) if (rq[j].due > now && !squashed(rq[j].th)) keep.push_back(rq[j]);
      rq = keep;
    end
    exp_slots = rq.size();
    now++;
  endtask

  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      model_cycle();
    end
  end

  function automatic logic [15:0] l4(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  task automatic step(input logic [3:0] v, input logic [15:0] l, input logic [3:0] th,
                      input logic m0, input logic m1, input logic rs);
    @(posedge clock);
    #1;
    reset = rs; req_valid = v; req_lat = l; req_thread = th;
    mispredict_0 = m0; mispredict_1 = m1;
    #3;
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'b0, 16'b0, 4'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held with random requests
    for (int j = 0; j < 2; j++) begin
      step(4'($urandom), 16'($urandom), 4'($urandom), 1'b0, 1'b0, 1'b1);
      chk("reset_grant", int'(grant), 0);
    end
    chk("reset_wb_valid", int'(wb_valid), 0);
    chk("reset_slots_used", int'(slots_used), 0);
    for (int j = 0; j < 10; j++) begin
      idle(1);
      chk("post_reset_wb_valid", int'(wb_valid), 0);
    end

    // Single reservation: mult, L=4, thread 1
    step(4'b0100, l4(0, 0, 4, 0), 4'b0100, 1'b0, 1'b0, 1'b0);
    chk("single_grant", int'(grant), 4'b0100);
    chk("single_lane", int'(grant_lane[2]), 0);
    for (int j = 1; j <= 5; j++) begin
      idle(1);
      chk("single_slots_used", int'(slots_used), (j <= 4) ? 1 : 0);
      chk("single_wb_valid", int'(wb_valid), (j == 4) ? 1 : 0);
      if (j == 4) begin
        chk("single_wb_src0", int'(wb_src[1:0]), 2);
        chk("single_wb_thread0", int'(wb_thread[0]), 1);
      end
    end

    // Lane contention
    step(4'b0101, l4(3, 0, 3, 0), 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("cont_grant", int'(grant), 4'b0101);
    chk("cont_lane_mult", int'(grant_lane[2]), 0);
    chk("cont_lane_alu0", int'(grant_lane[0]), 1);
    step(4'b0010, l4(0, 2, 0, 0), 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("cont_alu1_denied", int'(grant), 0);
    idle(2);
    chk("cont_wb_valid", int'(wb_valid), 2'b11);
    chk("cont_wb_src", int'(wb_src), 4'b0010);
    idle(2);

    // Priority: all four requesters with L=1
    step(4'b1111, l4(1, 1, 1, 1), 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("prio_grant", int'(grant), 4'b1100);
    chk("prio_lane", int'(grant_lane), 4'b1000);
    idle(1);
    chk("prio_wb_valid", int'(wb_valid), 2'b11);
    chk("prio_wb_src", int'(wb_src), 4'b1110);
    idle(2);

    // Squash in flight
    step(4'b0011, l4(5, 5, 0, 0), 4'b0010, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(4'b1000, l4(0, 0, 0, 1), 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("squash_branch_denied", int'(grant), 0);
    chk("squash_slots_before", int'(slots_used), 2);
    idle(1);
    chk("squash_slots_after", int'(slots_used), 1);
    idle(2);
    chk("squash_wb_valid", int'(wb_valid), 2'b10);
    chk("squash_wb_thread1", int'(wb_thread[1]), 1);
    idle(2);

    // Squash in the writeback cycle itself
    step(4'b0011, l4(5, 5, 0, 0), 4'b0010, 1'b0, 1'b0, 1'b0);
    idle(4);
    step(4'b0000, 16'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("squash_now_wb_valid", int'(wb_valid), 2'b10);
    idle(2);

    // Illegal latencies and mid-operation reset
    step(4'b0001, l4(0, 0, 0, 0), 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("lat0_err", int'(lat_err), 1);
    chk("lat0_grant", int'(grant), 0);
    step(4'b0001, l4(9, 0, 0, 0), 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("lat9_err", int'(lat_err), 1);
    chk("lat9_grant", int'(grant), 0);
    idle(1);
    chk("illegal_slots_used", int'(slots_used), 0);
    step(4'b0001, l4(6, 0, 0, 0), 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("midrst_grant", int'(grant), 4'b0001);
    idle(2);
    step(4'b0000, 16'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    for (int j = 4; j <= 6; j++) begin
      idle(1);
      chk("midrst_wb_valid", int'(wb_valid), 0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] l;
      for (int i = 0; i < 4; i++)
        l[i*4 +: 4] = ($urandom % 10 == 0) ? 4'($urandom_range(0, 15) * (($urandom % 2) ? 1 : 0) + 9 * ($urandom % 2))
                                           : 4'($urandom_range(1, H));
      step(4'($urandom), l, 4'($urandom), ($urandom % 8 == 0), ($urandom % 8 == 0),
           ($urandom % 300 == 0));
    end
    idle(12);
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
